// File: rtl/sram22_req_frontend.sv
// Request front-end for a single-port SRAM22 macro: issues reads/writes, tracks
// the one-cycle read latency and buffers responses with credit-based flow control.
// Optional power-on zero fill of the macro: define SRAM22_REQ_FRONTEND_INIT_EN.
module sram22_req_frontend #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_din,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_dout,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   init_done
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;

  state_t                               state;
  logic                                 rd_pend;
  logic [CW-1:0]                        count;
  logic [PW-1:0]                        wptr, rptr;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                                 run, fire, push, pop;
  logic [OW-1:0]                        occ;

  assign run       = (state == ST_RUN);
  assign init_done = run;
  assign push      = rd_pend;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_valid = (count != '0);
  assign rsp_dout  = mem[rptr];

  // Occupancy after this cycle's pop, counting the read still in the macro;
  // accepting only below RSP_DEPTH reserves a slot for every in-flight read.
  assign occ       = {1'b0, count} + OW'(rd_pend) - OW'(pop);
  assign req_ready = run & (occ < OW'(RSP_DEPTH));
  assign fire      = req_valid & req_ready;

`ifdef SRAM22_REQ_FRONTEND_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_wr;

  assign init_wr = (state == ST_INIT) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else if (state == ST_INIT) begin
      init_addr <= init_addr + ADDR_WIDTH'(1);
      if (init_addr == '1) state <= ST_RUN;
    end
  end

  always_comb begin
    sram_we    = init_wr | (fire & req_we);
    sram_wmask = init_wr ? '1 : req_wmask;
    sram_addr  = init_wr ? init_addr : req_addr;
    sram_din   = init_wr ? '0 : req_din;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= ST_RUN;
  end

  always_comb begin
    sram_we    = fire & req_we;
    sram_wmask = req_wmask;
    sram_addr  = req_addr;
    sram_din   = req_din;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      count   <= '0;
      wptr    <= '0;
      rptr    <= '0;
    end else begin
      rd_pend <= fire & ~req_we;
      if (push) wptr <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Macro dout is valid in the cycle after the read was sampled.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sram_dout;
  end
endmodule

// File: tb/tb_sram22_req_frontend.sv
// Bench for sram22_req_frontend: behavioural macro, request-level model with
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_sram22_req_frontend;
  localparam int DW = 32, AW = 9, MW = 1, DEPTH = 2, RAM_DEPTH = 512, SL = DW / MW;
`ifdef SRAM22_REQ_FRONTEND_INIT_EN
  localparam int INIT_CYC = RAM_DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 0, req_ready, req_we = 0;
  logic [MW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_din = '0;
  logic          rsp_valid, rsp_ready = 0;
  logic [DW-1:0] rsp_dout;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          init_done;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sram22_req_frontend #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_din(req_din), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dout(rsp_dout), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .init_done(init_done));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural SRAM22 macro: registered read data, masked write.
  logic [DW-1:0] ram [RAM_DEPTH];
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = 32'hA5A5_0000 | i;
    sram_dout = '0;
    forever begin
      @(posedge clk);
      if (sram_we) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) ram[sram_addr][b*SL +: SL] = sram_din[b*SL +: SL];
      end else sram_dout <= ram[sram_addr];
    end
  end

  // Request-level model: memory image, expected response queue, one pending read.
  logic [DW-1:0] mmem [RAM_DEPTH];
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_data;
  int            m_pend = 0, edges = 0;

  initial begin
    int mpop, mrdy;
    for (int i = 0; i < RAM_DEPTH; i++) mmem[i] = 32'hA5A5_0000 | i;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_pend = 0;
        edges  = 0;
      end else begin
        mpop = (q.size() > 0 && rsp_ready) ? 1 : 0;
        mrdy = (edges >= INIT_CYC && (q.size() + m_pend - mpop) < DEPTH) ? 1 : 0;
        if (dut.rd_pend)
          chk("push_when_full", 32'(dut.count == DEPTH && !(dut.rsp_valid && rsp_ready)), 0);
        if (mpop != 0) void'(q.pop_front());
        if (m_pend != 0) q.push_back(m_data);
        m_pend = 0;
        if (req_valid && mrdy != 0) begin
          if (req_we) begin
            for (int b = 0; b < MW; b++)
              if (req_wmask[b]) mmem[req_addr][b*SL +: SL] = req_din[b*SL +: SL];
          end else begin
            m_pend = 1;
            m_data = mmem[req_addr];
          end
        end
`ifdef SRAM22_REQ_FRONTEND_INIT_EN
        if (edges == INIT_CYC - 1) for (int i = 0; i < RAM_DEPTH; i++) mmem[i] = '0;
`endif
        if (edges < INIT_CYC) edges++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int erdy, epop, erun;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_sram_we", 32'(sram_we), 0);
        chk("rst_init_done", 32'(init_done), 0);
      end else begin
        erun = (edges >= INIT_CYC) ? 1 : 0;
        epop = (q.size() > 0 && rsp_ready) ? 1 : 0;
        erdy = (erun != 0 && (q.size() + m_pend - epop) < DEPTH) ? 1 : 0;
        chk("init_done", 32'(init_done), 32'(erun));
        chk("req_ready", 32'(req_ready), 32'(erdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("rsp_dout", rsp_dout, q[0]);
        if (erun != 0) begin
          chk("sram_we", 32'(sram_we), 32'(req_valid && erdy != 0 && req_we));
          chk("sram_addr", 32'(sram_addr), 32'(req_addr));
          chk("sram_din", sram_din, req_din);
          chk("sram_wmask", 32'(sram_wmask), 32'(req_wmask));
        end else begin
`ifdef SRAM22_REQ_FRONTEND_INIT_EN
          chk("init_we", 32'(sram_we), 1);
          chk("init_addr", 32'(sram_addr), 32'(edges));
          chk("init_din", sram_din, 0);
          chk("init_wmask", 32'(sram_wmask), 32'({MW{1'b1}}));
`else
          chk("idle_we", 32'(sram_we), 0);
`endif
        end
      end
    end
  end

  // Response capture for the directed scenarios.
  logic [DW-1:0] got [$];
  always @(negedge clk) if (rsp_valid && rsp_ready) got.push_back(rsp_dout);

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m, output int stalls);
    logic acc;
    int   n;
    req_valid = 1; req_we = we; req_addr = a; req_din = d; req_wmask = m;
    acc = 0; n = 0; stalls = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #2;
      if (!acc) stalls++;
      n++;
    end
    chk("issue_accepted", 32'(acc), 1);
    req_valid = 0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    chk("init_done_low_after_rst", 32'(init_done), 0);
    while (!init_done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("init_latency", 32'(n), 32'(INIT_CYC));
    #1;
  endtask

  initial begin
    int st, tot;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    step(3);
    chk("rst_rsp_valid_lit", 32'(rsp_valid), 0);
    chk("rst_req_ready_lit", 32'(req_ready), 0);
    rst = 0;
    wait_init();

    // write then read the same word on the next cycle
    rsp_ready = 1;
    issue(1, 5, 32'hDEADBEEF, 1'b1, st);
    got.delete();
    issue(0, 5, '0, '0, st);
    chk("raw_not_yet_valid", 32'(rsp_valid), 0);
    step(1);
    chk("raw_valid", 32'(rsp_valid), 1);
    chk("raw_data", rsp_dout, 32'hDEADBEEF);
    step(1);
    chk("raw_single_rsp", 32'(rsp_valid), 0);
    chk("raw_count", 32'(got.size()), 1);

    // streaming reads at full rate
    for (int i = 0; i < 16; i++) issue(1, AW'(i), 32'(i * 3), 1'b1, st);
    got.delete();
    tot = 0;
    for (int i = 0; i < 16; i++) begin issue(0, AW'(i), '0, '0, st); tot += st; end
    step(3);
    chk("stream_stalls", 32'(tot), 0);
    chk("stream_count", 32'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("stream_data", got[i], 32'(i * 3));

    // back-pressure fills exactly DEPTH entries
    rsp_ready = 0;
    got.delete();
    issue(0, 0, '0, '0, st);
    issue(0, 1, '0, '0, st);
    req_valid = 1; req_we = 0; req_addr = 2;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("bp_ready_low", 32'(req_ready), 0);
      chk("bp_head_stable", rsp_dout, 0);
    end
    rsp_ready = 1;
    #1;
    chk("bp_ready_reassert", 32'(req_ready), 1);
    #1;
    step(1);
    req_valid = 0;
    step(4);
    chk("bp_count", 32'(got.size()), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", got[i], 32'(i * 3));

    // masked-off write leaves data intact
    issue(1, 7, 32'h12345678, 1'b1, st);
    issue(1, 7, 32'hFFFFFFFF, 1'b0, st);
    got.delete();
    issue(0, 7, '0, '0, st);
    step(3);
    chk("mask_count", 32'(got.size()), 1);
    if (got.size() > 0) chk("mask_data", got[0], 32'h12345678);

    // reset with one buffered response and one read in flight
    rsp_ready = 0;
    issue(0, 1, '0, '0, st);
    issue(0, 2, '0, '0, st);
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    req_valid = 1; req_we = 1; req_addr = 9; req_wmask = 1'b1;
    rst = 1;
    #1;
    chk("rst_now_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_now_sram_we", 32'(sram_we), 0);
    chk("rst_now_req_ready", 32'(req_ready), 0);
    #1;
    step(3);
    req_valid = 0;
    rst = 0;
    wait_init();
    rsp_ready = 1;
    got.delete();
    step(5);
    chk("no_stale_rsp", 32'(got.size()), 0);

    // top word after (optional) zero fill
    got.delete();
    issue(0, 511, '0, '0, st);
    step(3);
    chk("top_count", 32'(got.size()), 1);
`ifdef SRAM22_REQ_FRONTEND_INIT_EN
    if (got.size() > 0) chk("top_data", got[0], 32'h0);
`else
    if (got.size() > 0) chk("top_data", got[0], 32'hA5A5_01FF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram22_req_frontend.md
Name: sram22_req_frontend

Overview:
- Request front-end placed directly upstream of a single-port SRAM22 macro. Both blocks share one clock.
- Takes valid/ready read/write requests and drives the macro's we/wmask/addr/din.
- Tracks the macro's one-cycle read latency. Captures dout into a small response FIFO with valid/ready back-pressure.
- Never drops a read response.

Parameters:
- DATA_WIDTH, 32, data word width; equals the macro word size.
- ADDR_WIDTH, 9, address width; macro depth = 1<<ADDR_WIDTH.
- WMASK_WIDTH, 1, write-mask bits; each bit covers DATA_WIDTH/WMASK_WIDTH bits.
- RSP_DEPTH, 2, response FIFO entries; legal range 2..8.

Ports:
- clk  in  1  clock, shared with the SRAM macro.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_we  in  1  1=write, 0=read.
- req_wmask  in  WMASK_WIDTH  write mask for write requests.
- req_addr  in  ADDR_WIDTH  word address.
- req_din  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data available at FIFO head.
- rsp_ready  in  1  consumer pops the head when high together with rsp_valid.
- rsp_dout  out  DATA_WIDTH  read data at FIFO head.
- sram_we  out  1  to macro we.
- sram_wmask  out  WMASK_WIDTH  to macro wmask.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.
- init_done  out  1  high once the block accepts requests.

Behaviour:
- Reset (async, active-high) clears rd_pend, the FIFO count and pointers, and the FSM state. During and after reset: rsp_valid=0, req_ready=0 until RUN, sram_we=0.
- fire = req_valid & req_ready.
- In RUN the SRAM outputs are combinational:
  - sram_we = fire & req_we
  - sram_addr = req_addr
  - sram_din = req_din
  - sram_wmask = req_wmask
- The macro samples them at the same clk edge. When sram_we=0 the macro performs a read; this is harmless and untracked unless fire & !req_we.
- rd_pend register: set at an edge where fire & !req_we; otherwise cleared.
- At an edge where rd_pend=1, sram_dout is pushed into the FIFO tail.
- Latency: read accepted at edge N → data enters the FIFO at edge N+1 → rsp_valid=1 in cycle N+1 (earliest).
- Credit rule: req_ready = RUN & (count + rd_pend - (rsp_valid & rsp_ready)) < RSP_DEPTH. There is a combinational path from rsp_ready to req_ready. This guarantees a free slot for every in-flight read.
- Full throughput: back-to-back reads, one per cycle, sustain with rsp_ready=1 held high.
- Writes produce no response and consume no credit beyond the rule above. A write may issue while a read is pending; the pending read's data is unaffected.
- FIFO behaviour:
  - Circular, pointers wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle: count is unchanged.
  - Pop on empty is impossible because rsp_valid=0.
  - Push when full cannot occur by construction; the bench asserts this.
- rsp_dout is the head entry; it is held stable while rsp_valid & !rsp_ready.
- Read-after-write to the same address in consecutive cycles returns the new data. The macro orders this itself; no forwarding is needed.
- Reset mid-operation: the pending read and all FIFO contents are discarded. No response is produced for them.

Optional Feature:
- Macro: SRAM22_REQ_FRONTEND_INIT_EN.
- Defined: after reset the FSM enters INIT.
  - In INIT it writes zero to every address 0..RAM_DEPTH-1, one per cycle: sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=init counter.
  - During INIT, req_ready=0 and init_done=0.
  - After the write to address RAM_DEPTH-1 it moves to RUN; init_done=1 from the next cycle.
  - Takes RAM_DEPTH cycles. Reset during INIT restarts the walk at address 0.
- Undefined: reset goes straight to RUN; init_done=1 in the first cycle after reset deassertion. No init counter is built.

Test Plan:
- Write 0xDEADBEEF to addr 5, then read addr 5 the next cycle with rsp_ready=1 → rsp_valid exactly one cycle after the read is accepted, rsp_dout=0xDEADBEEF, one response only.
- 16 back-to-back reads of addrs 0..15 (preloaded addr*3), rsp_ready=1 → req_ready stays 1; responses in order 0,3,...,45, one per cycle.
- Hold rsp_ready=0 and issue reads → exactly RSP_DEPTH (2) responses are buffered, then req_ready=0. Release rsp_ready → data is drained in order and req_ready reasserts. No push-when-full assertion fires.
- Write with wmask=0 to addr 7 holding 0x12345678, then read addr 7 → 0x12345678.
- Assert rst while a read is pending and the FIFO holds 1 entry → rsp_valid=0 immediately, sram_we=0, and no stale response appears after reset release.
- With SRAM22_REQ_FRONTEND_INIT_EN defined: init_done rises exactly 512 cycles after reset release, req_ready=0 before that, and a read of addr 511 returns 0. Without the macro: init_done=1 in the first post-reset cycle.
